threshold_burst_gate: RTL and testbench

THRESHOLD_BURST_GATE -- requirements
Module: threshold_burst_gate

---
 rtl/threshold_burst_gate_pkg.sv | 18 +
 rtl/threshold_burst_gate_if.sv | 31 +++
 rtl/threshold_burst_gate_join.sv | 16 +
 rtl/threshold_burst_gate.sv | 116 +++++++++++
 tb/tb_threshold_burst_gate.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/threshold_burst_gate_pkg.sv
// rtl/threshold_burst_gate_pkg.sv - shared state encoding and counter sizing for threshold_burst_gate
package threshold_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Counters only ever hold limit-1, so clog2 of the largest limit is enough.
  function automatic int cnt_width(input int min_on, input int hang, input int max_len);
    int m;
    m = min_on;
    if (hang > m) m = hang;
    if (max_len > m) m = max_len;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/threshold_burst_gate_if.sv
// rtl/threshold_burst_gate_if.sv - sample, flag and gated-output streams of threshold_burst_gate
interface threshold_burst_gate_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;

  logic             t_tdata;
  logic             t_tlast;
  logic             t_tvalid;
  logic             t_tready;

  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, t_tdata, t_tlast, t_tvalid, o_tready,
    output i_tready, t_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, t_tdata, t_tlast, t_tvalid, o_tready,
    input  i_tready, t_tready, o_tdata, o_tlast, o_tvalid
  );

endinterface

// File: rtl/threshold_burst_gate_join.sv
// rtl/threshold_burst_gate_join.sv - two-stream join: both inputs consumed together when the sink can accept
module axi_join2 (
  input  logic a_valid,
  input  logic b_valid,
  input  logic out_ready,
  input  logic block,
  output logic a_ready,
  output logic b_ready,
  output logic fire
);

  assign fire    = a_valid & b_valid & out_ready & ~block;
  assign a_ready = fire;
  assign b_ready = fire;

endmodule

// File: rtl/threshold_burst_gate.sv
// rtl/threshold_burst_gate.sv - passes sample bursts qualified by a threshold flag stream
// Optional completed-burst counter: define THRESH_GATE_BURST_CNT_EN.
module threshold_burst_gate
  import threshold_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MIN_ON  = 4,
  parameter int HANG    = 16,
  parameter int MAX_LEN = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  threshold_burst_gate_if.slave bus
`ifdef THRESH_GATE_BURST_CNT_EN
  ,
  output logic [31:0]           burst_count
`endif
);

  localparam int CW = cnt_width(MIN_ON, HANG, MAX_LEN);
  localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(HANG - 1);
  localparam logic [CW-1:0] LEN_LAST = CW'(MAX_LEN - 1);

  state_t        state, state_nx;
  logic [CW-1:0] on_cnt, off_cnt, len_cnt;
  logic          take, flag, open_hit, pass, end_burst, out_ready;

  assign flag      = bus.t_tdata;
  assign out_ready = ~bus.o_tvalid | bus.o_tready;

  axi_join2 u_join (
    .a_valid   (bus.i_tvalid),
    .b_valid   (bus.t_tvalid),
    .out_ready (out_ready),
    .block     (reset | clear),
    .a_ready   (bus.i_tready),
    .b_ready   (bus.t_tready),
    .fire      (take)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) state <= ST_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pass && !end_burst) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (end_burst)          state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // A burst opened in IDLE can only end at once through i_tlast (single-sample burst).
  always_comb begin
    open_hit  = flag && (on_cnt == ON_LAST);
    pass      = take && ((state == ST_ACTIVE) || open_hit);
    end_burst = pass && (bus.i_tlast ||
                ((state == ST_ACTIVE) && ((!flag && (off_cnt == OFF_LAST)) || (len_cnt == LEN_LAST))));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      on_cnt  <= '0;
      off_cnt <= '0;
      len_cnt <= '0;
    end else if (take) begin
      if (state == ST_IDLE) begin
        if (!flag) begin
          on_cnt <= '0;
        end else if (open_hit) begin
          on_cnt  <= '0;
          off_cnt <= '0;
          len_cnt <= bus.i_tlast ? '0 : CW'(1);
        end else begin
          on_cnt <= on_cnt + 1'b1;
        end
      end else if (end_burst) begin
        on_cnt  <= '0;
        off_cnt <= '0;
        len_cnt <= '0;
      end else begin
        len_cnt <= len_cnt + 1'b1;
        off_cnt <= flag ? '0 : off_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.o_tvalid <= 1'b0;
      bus.o_tlast  <= 1'b0;
      bus.o_tdata  <= '0;
    end else if (clear) begin
      bus.o_tvalid <= 1'b0;
      bus.o_tlast  <= 1'b0;
    end else if (pass) begin
      bus.o_tvalid <= 1'b1;
      bus.o_tdata  <= bus.i_tdata;
      bus.o_tlast  <= end_burst;
    end else if (bus.o_tready) begin
      bus.o_tvalid <= 1'b0;
    end
  end

`ifdef THRESH_GATE_BURST_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || clear)                                  burst_count <= '0;
    else if (bus.o_tvalid && bus.o_tready && bus.o_tlast) burst_count <= burst_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_threshold_burst_gate.sv
// tb/tb_threshold_burst_gate.sv - randomized self-checking bench for threshold_burst_gate
module tb_threshold_burst_gate;
  import threshold_pkg::*;

  typedef struct packed {logic [31:0] d; logic f; logic l;} smp_t;
  typedef struct packed {logic [31:0] d; logic l;} out_t;

  logic clk = 1'b0;
  logic reset, clear;
  always #5 clk = ~clk;

  threshold_burst_gate_if ifa ();
  threshold_burst_gate_if ifb ();

`ifdef THRESH_GATE_BURST_CNT_EN
  logic [31:0] bc_a, bc_b;
`endif

  threshold_burst_gate #(.WIDTH(32), .MIN_ON(4), .HANG(3), .MAX_LEN(16)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .bus(ifa)
`ifdef THRESH_GATE_BURST_CNT_EN
    , .burst_count(bc_a)
`endif
  );

  threshold_burst_gate #(.WIDTH(32), .MIN_ON(2), .HANG(3), .MAX_LEN(4)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .bus(ifb)
`ifdef THRESH_GATE_BURST_CNT_EN
    , .burst_count(bc_b)
`endif
  );

  smp_t in_q[$];
  out_t exp_q[$];
  out_t act_q[$];
  int checks = 0;
  int failures = 0;

  function automatic int p_min_on(int w);  return (w == 0) ? 4 : 2;  endfunction
  function automatic int p_max_len(int w); return (w == 0) ? 16 : 4; endfunction
  localparam int P_HANG = 3;

  task automatic set_in(int w, smp_t s, bit vi, bit vt, bit r);
    if (w == 0) begin
      ifa.i_tdata = s.d; ifa.t_tdata = s.f; ifa.i_tlast = s.l; ifa.t_tlast = 1'b0;
      ifa.i_tvalid = vi; ifa.t_tvalid = vt; ifa.o_tready = r;
    end else begin
      ifb.i_tdata = s.d; ifb.t_tdata = s.f; ifb.i_tlast = s.l; ifb.t_tlast = 1'b0;
      ifb.i_tvalid = vi; ifb.t_tvalid = vt; ifb.o_tready = r;
    end
  endtask

  task automatic get_out(int w, output logic [31:0] d, output logic l, output logic v,
                         output logic ir, output logic tr);
    if (w == 0) begin d = ifa.o_tdata; l = ifa.o_tlast; v = ifa.o_tvalid; ir = ifa.i_tready; tr = ifa.t_tready; end
    else        begin d = ifb.o_tdata; l = ifb.o_tlast; v = ifb.o_tvalid; ir = ifb.i_tready; tr = ifb.t_tready; end
  endtask

`ifdef THRESH_GATE_BURST_CNT_EN
  function automatic logic [31:0] get_cnt(int w);
    return (w == 0) ? bc_a : bc_b;
  endfunction
`endif

  task automatic idle_all();
    set_in(0, '0, 1'b0, 1'b0, 1'b0);
    set_in(1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    reset = 1'b1;
    idle_all();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Reference: a burst opens on the min_on-th consecutive 1, then passes everything
  // until hang zeros in a row, max_len samples, or a tlast sample.
  function automatic void build_model(int min_on, int hang, int max_len);
    bit on = 0;
    int run = 0, zeros = 0, len = 0;
    bit endb;
    exp_q.delete();
    foreach (in_q[i]) begin
      if (!on) begin
        run = in_q[i].f ? run + 1 : 0;
        if (run != min_on) continue;
        on = 1; run = 0; len = 0; zeros = 0;
      end
      len++;
      zeros = in_q[i].f ? 0 : zeros + 1;
      endb = in_q[i].l || (zeros == hang) || (len == max_len);
      exp_q.push_back('{in_q[i].d, endb});
      if (endb) on = 0;
    end
  endfunction

  function automatic int exp_bursts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].l) n++;
    return n;
  endfunction

  task automatic run_stream(int w, int rpct, int vpct, string name);
    int idx = 0, cyc = 0, n;
    bit vi, vt, r, holding = 0;
    logic [31:0] od, hd;
    logic ol, ov, ir, tr, hl;
    n = in_q.size();
    build_model(p_min_on(w), P_HANG, p_max_len(w));
    act_q.delete();
    while (!(idx == n && act_q.size() >= exp_q.size())) begin
      if (cyc > n * 20 + 100) begin
        checks++; failures++;
        $display("FAIL %s timeout taken=%0d/%0d outputs=%0d/%0d", name, idx, n, act_q.size(), exp_q.size());
        break;
      end
      cyc++;
      vi = (idx < n) && ($urandom_range(99) < vpct);
      vt = (idx < n) && ($urandom_range(99) < vpct);
      r  = ($urandom_range(99) < rpct);
      set_in(w, (idx < n) ? in_q[idx] : '0, vi, vt, r);
      #1;
      get_out(w, od, ol, ov, ir, tr);
      checks++;
      if (ir !== (vi & vt & (~ov | r)) || tr !== ir) begin
        failures++;
        $display("FAIL %s ready i_tready=%b t_tready=%b expected=%b", name, ir, tr, vi & vt & (~ov | r));
      end
      if (holding) begin
        checks++;
        if (ov !== 1'b1 || od !== hd || ol !== hl) begin
          failures++;
          $display("FAIL %s stall valid=%b data=%h last=%b expected data=%h last=%b", name, ov, od, ol, hd, hl);
        end
      end
      holding = (ov === 1'b1) && !r;
      hd = od; hl = ol;
      if (ov === 1'b1 && r) act_q.push_back('{od, ol});
      if (ir === 1'b1) idx++;
      @(posedge clk);
      @(negedge clk);
    end
    set_in(w, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s count actual=%0d expected=%0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s out[%0d] actual=%h/%b expected=%h/%b", name, i, act_q[i].d, act_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
`ifdef THRESH_GATE_BURST_CNT_EN
    checks++;
    if (get_cnt(w) !== 32'(exp_bursts())) begin
      failures++;
      $display("FAIL %s burst_count actual=%0d expected=%0d", name, get_cnt(w), exp_bursts());
    end
`endif
  endtask

  task automatic load_flags(input logic [7:0] flags, input int n, input int last_idx);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back('{32'(i), flags[n-1-i], (i == last_idx)});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    set_in(0, '{32'h5, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b1);
    set_in(1, '{32'h5, 1'b1, 1'b0}, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ifa.i_tready !== 1'b0 || ifa.t_tready !== 1'b0 || ifb.i_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready actual=%b%b%b expected=000", ifa.i_tready, ifa.t_tready, ifb.i_tready);
    end
    checks++;
    if (ifa.o_tvalid !== 1'b0 || ifa.o_tlast !== 1'b0 || ifa.o_tdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_out actual=%b/%b/%h expected=0/0/0", ifa.o_tvalid, ifa.o_tlast, ifa.o_tdata);
    end
    checks++;
    if (dut_a.state !== ST_IDLE || dut_b.state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state actual=%0d/%0d expected=0", dut_a.state, dut_b.state);
    end
`ifdef THRESH_GATE_BURST_CNT_EN
    checks++;
    if (bc_a !== 32'd0) begin
      failures++;
      $display("FAIL reset_burst_count actual=%0d expected=0", bc_a);
    end
`endif
    do_reset();
  endtask

  task automatic test_hang_end();
    do_reset();
    load_flags(8'b1111_1000, 8, -1);
    run_stream(0, 100, 100, "hang_end");
    checks++;
    if (act_q.size() != 5 || act_q[0].d !== 32'd3 || act_q[4] !== '{32'd7, 1'b1}) begin
      failures++;
      $display("FAIL hang_end_shape outputs=%0d expected 5 from 3 to 7 with last", act_q.size());
    end
    checks++;
    if (dut_a.state !== ST_IDLE) begin
      failures++;
      $display("FAIL hang_end_state actual=%0d expected=%0d", dut_a.state, ST_IDLE);
    end
  endtask

  task automatic test_requalify();
    do_reset();
    load_flags(8'b1110_1111, 8, -1);
    run_stream(0, 100, 100, "requalify");
    checks++;
    if (act_q.size() != 1 || act_q[0].d !== 32'd7) begin
      failures++;
      $display("FAIL requalify_first outputs=%0d expected single sample 7", act_q.size());
    end
  endtask

  task automatic test_max_len();
    do_reset();
    in_q.delete();
    for (int i = 0; i < 20; i++) in_q.push_back('{32'(100 + i), 1'b1, 1'b0});
    run_stream(1, 100, 100, "max_len");
    checks++;
    if (act_q.size() != 16 || act_q[0].d !== 32'd101 || act_q[4].d !== 32'd106 || act_q[3].l !== 1'b1) begin
      failures++;
      $display("FAIL max_len_shape outputs=%0d expected 16 in bursts of 4", act_q.size());
    end
  endtask

  task automatic test_random_stall();
    for (int w = 0; w < 2; w++) begin
      do_reset();
      in_q.delete();
      for (int i = 0; i < 200; i++)
        in_q.push_back('{$urandom, ($urandom_range(99) < 75), ($urandom_range(99) < 4)});
      run_stream(w, 50, 80, (w == 0) ? "random_stall_a" : "random_stall_b");
    end
  endtask

  task automatic test_clear();
    int seen = 0, j = 0;
    do_reset();
    while (seen < 2 && j < 20) begin
      set_in(0, '{32'(j), 1'b1, 1'b0}, 1'b1, 1'b1, 1'b1);
      @(posedge clk); @(negedge clk); #1;
      if (ifa.o_tvalid === 1'b1) seen++;
      j++;
    end
    clear = 1'b1;
    set_in(0, '{32'(j), 1'b1, 1'b0}, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (ifa.i_tready !== 1'b0 || seen != 2) begin
      failures++;
      $display("FAIL clear_take i_tready=%b seen=%0d expected 0 and 2", ifa.i_tready, seen);
    end
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (ifa.o_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL clear_valid actual=%b expected=0", ifa.o_tvalid);
    end
    for (int k = 0; k < 4; k++) begin
      set_in(0, '{32'(50 + k), 1'b1, 1'b0}, 1'b1, 1'b1, 1'b1);
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (ifa.o_tvalid !== (k == 3)) begin
        failures++;
        $display("FAIL clear_requalify k=%0d valid=%b expected=%b", k, ifa.o_tvalid, (k == 3));
      end
    end
    checks++;
    if (ifa.o_tdata !== 32'd53 || ifa.o_tlast !== 1'b0) begin
      failures++;
      $display("FAIL clear_first data=%0d last=%b expected=53/0", ifa.o_tdata, ifa.o_tlast);
    end
`ifdef THRESH_GATE_BURST_CNT_EN
    checks++;
    if (bc_a !== 32'd0) begin
      failures++;
      $display("FAIL clear_burst_count actual=%0d expected=0", bc_a);
    end
`endif
    set_in(0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tlast_hang();
    int lasts = 0;
    do_reset();
    load_flags(8'b0111_1000, 7, 6);
    run_stream(0, 100, 100, "tlast_hang");
    foreach (act_q[i]) if (act_q[i].l) lasts++;
    checks++;
    if (lasts != 1 || act_q.size() != 4) begin
      failures++;
      $display("FAIL tlast_hang_single lasts=%0d outputs=%0d expected=1/4", lasts, act_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    idle_all();
    test_reset();
    test_hang_end();
    test_requalify();
    test_max_len();
    test_random_stall();
    test_clear();
    test_tlast_hang();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
